watch_set_ctrl: RTL

Time/date set controller for the watch. When `active` is raised it snapshots the running time, lets the user step a cursor across six fields and increment or decrement them with calendar-correct wrap. When `active` is dropped it presents the edited value on `bin_time` with a one-cycle `en_time` load strobe, so the timekeeping counter can reload from it. It sits between the push-button front end and the watch counter.

---
 rtl/watch_set_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/watch_set_ctrl.sv
// Time/date set controller: snapshot live time, edit six fields with calendar wrap, commit with a load strobe.
// Optional day clamping on month/year change and on commit: define WATCH_SET_DAY_CLAMP_EN.
module watch_set_ctrl #(
    parameter int unsigned YEAR_MAX = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        active,
    input  logic [3:0]  sw_in,
    input  logic [7:0]  year,
    input  logic [7:0]  month,
    input  logic [7:0]  day,
    input  logic [7:0]  hour,
    input  logic [7:0]  minute,
    input  logic [7:0]  second,
    output logic [47:0] bin_time,
    output logic        en_time,
    output logic [4:0]  cursor,
    output logic        editing
);

    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

    localparam int F_YEAR  = 0;
    localparam int F_MONTH = 1;
    localparam int F_DAY   = 2;

    state_t      state_q, state_d;
    logic [7:0]  fld_q [6];
    logic [7:0]  fld_d [6];
    logic [2:0]  cur_q, cur_d;
    logic [3:0]  sw_q;
    logic        en_q, en_d;
    logic        ed_q, ed_d;
    logic [3:0]  edge_w;
    logic [7:0]  lo_w, hi_w;

    function automatic logic [7:0] dim(input logic [7:0] m, input logic [7:0] y);
        logic [7:0] r;
        case (m)
            8'd2:                      r = (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11:   r = 8'd30;
            default:                   r = 8'd31;
        endcase
        return r;
    endfunction

    // Out-of-range values snap to the far end of the range for the step direction.
    function automatic logic [7:0] step_fld(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic up);
        logic [7:0] r;
        if (up) r = (v < lo || v >= hi) ? lo : v + 8'd1;
        else    r = (v <= lo || v > hi) ? hi : v - 8'd1;
        return r;
    endfunction

    assign edge_w = sw_in & ~sw_q;

    always_comb begin
        lo_w = 8'd0;
        hi_w = 8'd59;
        case (cur_q)
            3'd0:    hi_w = 8'(YEAR_MAX);
            3'd1:    begin lo_w = 8'd1; hi_w = 8'd12; end
            3'd2:    begin lo_w = 8'd1; hi_w = dim(fld_q[F_MONTH], fld_q[F_YEAR]); end
            3'd3:    hi_w = 8'd23;
            default: hi_w = 8'd59;
        endcase
    end

    always_comb begin
        state_d = state_q;
        fld_d   = fld_q;
        cur_d   = cur_q;
        case (state_q)
            S_IDLE: begin
                if (active) begin
                    fld_d   = '{year, month, day, hour, minute, second};
                    cur_d   = 3'd0;
                    state_d = S_EDIT;
                end
            end
            S_EDIT: begin
                if (!active) begin
                    state_d = S_COMMIT;
`ifdef WATCH_SET_DAY_CLAMP_EN
                    if (fld_q[F_DAY] > dim(fld_q[F_MONTH], fld_q[F_YEAR]))
                        fld_d[F_DAY] = dim(fld_q[F_MONTH], fld_q[F_YEAR]);
`endif
                end else if ($onehot(edge_w)) begin
                    if (edge_w[0])      cur_d = (cur_q == 3'd0) ? 3'd5 : cur_q - 3'd1;
                    else if (edge_w[1]) cur_d = (cur_q == 3'd5) ? 3'd0 : cur_q + 3'd1;
                    else                fld_d[cur_q] = step_fld(fld_q[cur_q], lo_w, hi_w, edge_w[2]);
`ifdef WATCH_SET_DAY_CLAMP_EN
                    if ((edge_w[2] || edge_w[3]) && cur_q <= 3'd1 &&
                        fld_d[F_DAY] > dim(fld_d[F_MONTH], fld_d[F_YEAR]))
                        fld_d[F_DAY] = dim(fld_d[F_MONTH], fld_d[F_YEAR]);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        en_d = (state_d == S_COMMIT);
        ed_d = (state_d == S_EDIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 6; i++) fld_q[i] <= 8'd0;
            cur_q   <= 3'd0;
            sw_q    <= 4'd0;
            en_q    <= 1'b0;
            ed_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            cur_q   <= cur_d;
            sw_q    <= sw_in;
            en_q    <= en_d;
            ed_q    <= ed_d;
        end
    end

    assign bin_time = {fld_q[0], fld_q[1], fld_q[2], fld_q[3], fld_q[4], fld_q[5]};
    assign en_time  = en_q;
    assign cursor   = {2'b00, cur_q};
    assign editing  = ed_q;

endmodule
